// File: rtl/switch_matrix_ctrl.sv
// switch_matrix_ctrl
//   Command-queued controller for N_SW MT8816 8x16 analog crosspoint chips.
//   The chips share AX/AY/DATA/STROBE and each has its own CS and RESET line.
//   Host commands (write switch / reset one chip / reset all) are queued in a
//   FIFO and replayed with programmable MT8816 timing. A power-up reset of all
//   chips runs after every release of rst.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     push handshake (ready = FIFO not full)
//   cmd_op              00 write, 01 reset chip cmd_sel, 10 reset all, 11 NOP
//   cmd_sel/x/y/data    target chip, logical column, row, close(1)/open(0)
//   busy                controller active or commands queued
//   done                1-cycle pulse at the end of each executed command
//   err                 1-cycle pulse when a popped command is dropped
//   sw_cs, sw_rst       per-chip CS and RESET, active-high
//   AX, AY, STROBE, DATA  shared MT8816 bus
module switch_matrix_ctrl #(
  parameter int N_SW     = 2,
  parameter int DEPTH    = 8,
  parameter int T_RESET  = 6,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 2,
  parameter int T_DELAY  = 9,
  localparam int SEL_W   = (N_SW > 1) ? $clog2(N_SW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [3:0]       cmd_x,
  input  logic [2:0]       cmd_y,
  input  logic             cmd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N_SW-1:0]  sw_cs,
  output logic [N_SW-1:0]  sw_rst,
  output logic [3:0]       AX,
  output logic [2:0]       AY,
  output logic             STROBE,
  output logic             DATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  localparam logic [SEL_W:0] N_SW_L = (SEL_W + 1)'(N_SW);

  typedef struct packed {
    logic [1:0]       op;
    logic [SEL_W-1:0] sel;
    logic [3:0]       x;
    logic [2:0]       y;
    logic             data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_INIT, S_RST, S_WAIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic          last;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, bad, good_pop;
  cmd_t          head, cmd_in;

  logic [SEL_W-1:0] work_sel;
  logic [N_SW-1:0]  rst_mask;
  logic             exec_flag;
  logic [3:0]       ax_q;
  logic [2:0]       ay_q;
  logic             data_q;

  // MT8816 X pins are not in logical order: X6..X11 sit at codes 8..13,
  // X12/X13 at codes 6/7.
  function automatic logic [3:0] remap_x(input logic [3:0] x);
    logic [3:0] r;
    if (x < 4'd6)       r = x;
    else if (x < 4'd12) r = x + 4'd2;
    else if (x == 4'd12) r = 4'd6;
    else if (x == 4'd13) r = 4'd7;
    else                r = x;
    return r;
  endfunction

  function automatic logic [N_SW-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_SW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (s == SEL_W'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] dur(input state_t s);
    logic [CW-1:0] r;
    case (s)
      S_RST:    r = CW'(T_RESET - 1);
      S_WAIT:   r = CW'(T_DELAY - 1);
      S_SETUP:  r = CW'(T_SETUP - 1);
      S_STROBE: r = CW'(T_STROBE - 1);
      S_HOLD:   r = CW'(T_HOLD - 1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  // ---------------- command FIFO ----------------
  assign cmd_in   = '{op: cmd_op, sel: cmd_sel, x: cmd_x, y: cmd_y, data: cmd_data};
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign push     = cmd_valid && cmd_ready;
  assign pop      = (state == S_IDLE) && !empty;
  assign head     = mem[rd_ptr];
  assign bad      = ({1'b0, head.sel} >= N_SW_L) || (head.op == 2'b11);
  assign good_pop = pop && !bad;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  // The dwell counter is reloaded on every state change and counts down to 0.
  assign last = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= dur(state_nx);
      else if (!last)        cnt <= cnt - 1'b1;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:   state_nx = S_RST;
      S_RST:    if (last) state_nx = S_WAIT;
      S_WAIT:   if (last) state_nx = S_IDLE;
      S_IDLE: begin
        if (good_pop) state_nx = (head.op == 2'b00) ? S_SETUP : S_RST;
      end
      S_SETUP:  if (last) state_nx = S_STROBE;
      S_STROBE: if (last) state_nx = S_HOLD;
      S_HOLD:   if (last) state_nx = S_WAIT;
      default:  state_nx = S_INIT;
    endcase
  end

  // ---------------- working registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_sel  <= '0;
      rst_mask  <= '0;
      exec_flag <= 1'b0;
      ax_q      <= '0;
      ay_q      <= '0;
      data_q    <= 1'b0;
    end else if (state == S_INIT) begin
      rst_mask  <= '1;
      exec_flag <= 1'b0;
    end else if (good_pop) begin
      exec_flag <= 1'b1;
      work_sel  <= head.sel;
      case (head.op)
        2'b00: begin
          ax_q   <= remap_x(head.x);
          ay_q   <= head.y;
          data_q <= head.data;
        end
        2'b01:   rst_mask <= onehot(head.sel);
        default: rst_mask <= '1;
      endcase
    end else if ((state == S_WAIT) && last) begin
      exec_flag <= 1'b0;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sw_cs     = '0;
    sw_rst    = '0;
    STROBE    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cmd_ready = !full && (state != S_INIT);
    busy      = ((state != S_IDLE) && (state != S_INIT)) || !empty;
    case (state)
      S_RST:    sw_rst = rst_mask;
      S_WAIT:   done   = last && exec_flag;
      S_IDLE:   err    = pop && bad;
      S_SETUP,
      S_HOLD:   sw_cs  = onehot(work_sel);
      S_STROBE: begin
        sw_cs  = onehot(work_sel);
        STROBE = 1'b1;
      end
      default: ;
    endcase
  end

  assign AX   = ax_q;
  assign AY   = ay_q;
  assign DATA = data_q;

endmodule

// File: tb/tb_switch_matrix_ctrl.sv
module tb_switch_matrix_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // two-chip instance
  logic       cmd_valid = 1'b0, cmd_data = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [0:0] cmd_sel = '0;
  logic [3:0] cmd_x = '0;
  logic [2:0] cmd_y = '0;
  logic       cmd_ready, busy, done, err, STROBE, DATA;
  logic [1:0] sw_cs, sw_rst;
  logic [3:0] AX;
  logic [2:0] AY;

  // three-chip instance
  logic       v3 = 1'b0, d3 = 1'b0;
  logic [1:0] op3 = '0, sel3 = '0;
  logic [3:0] x3 = '0;
  logic [2:0] y3 = '0;
  logic       rdy3, busy3, done3, err3, stb3, dat3;
  logic [2:0] cs3, srst3;
  logic [3:0] ax3;
  logic [2:0] ay3;

  int checks = 0;
  int failures = 0;

  logic [3:0] xs  [9] = '{4'd0, 4'd5, 4'd6, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd7};
  logic [3:0] pxs [9] = '{4'd0, 4'd5, 4'd8, 4'd13, 4'd6, 4'd7, 4'd14, 4'd15, 4'd9};

  switch_matrix_ctrl u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_data(cmd_data), .busy(busy), .done(done), .err(err),
    .sw_cs(sw_cs), .sw_rst(sw_rst), .AX(AX), .AY(AY), .STROBE(STROBE), .DATA(DATA)
  );

  switch_matrix_ctrl #(.N_SW(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3),
    .cmd_op(op3), .cmd_sel(sel3), .cmd_x(x3), .cmd_y(y3),
    .cmd_data(d3), .busy(busy3), .done(done3), .err(err3),
    .sw_cs(cs3), .sw_rst(srst3), .AX(ax3), .AY(ay3), .STROBE(stb3), .DATA(dat3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the INIT cycle right after rst is released.
  task automatic check_init();
    chk("init_rst_low", 32'(sw_rst), 32'(2'b00));
    chk("init_ready_low", 32'(cmd_ready), 32'(1'b0));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("init_rst_on", 32'(sw_rst), 32'(2'b11));
      chk("init_cs_off", 32'(sw_cs), 32'(2'b00));
    end
    for (int i = 0; i < 9; i++) begin
      step();
      chk("init_gap_rst", 32'(sw_rst), 32'(2'b00));
      chk("init_gap_busy", 32'(busy), 32'(1'b1));
      chk("init_no_done", 32'(done), 32'(1'b0));
    end
    step();
    chk("idle_ready", 32'(cmd_ready), 32'(1'b1));
    chk("idle_busy", 32'(busy), 32'(1'b0));
  endtask

  initial begin
    int pidx, sidx, rises, last_rise, cyc, dones, scnt, dcnt, ecnt, found;
    logic prev_stb, rdy;

    // ---- reset state ----
    step();
    step();
    chk("rst_sw_rst", 32'(sw_rst), 32'(2'b00));
    chk("rst_sw_cs", 32'(sw_cs), 32'(2'b00));
    chk("rst_ready", 32'(cmd_ready), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_strobe", 32'(STROBE), 32'(1'b0));
    chk("rst_ax", 32'(AX), 32'(4'd0));
    chk("rst_cs3", 32'(cs3), 32'(3'b000));
    rst = 1'b0;
    check_init();

    // ---- single write: sel1 x12 y5 d1 ----
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 1'b1;
    cmd_x = 4'd12; cmd_y = 3'd5; cmd_data = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("w_queued_busy", 32'(busy), 32'(1'b1));
    chk("w_no_cs_yet", 32'(sw_cs), 32'(2'b00));
    step();
    chk("w_cs", 32'(sw_cs), 32'(2'b10));
    chk("w_ax", 32'(AX), 32'(4'd6));
    chk("w_ay", 32'(AY), 32'(3'd5));
    chk("w_data", 32'(DATA), 32'(1'b1));
    chk("w_setup_stb", 32'(STROBE), 32'(1'b0));
    step();
    chk("w_setup2_stb", 32'(STROBE), 32'(1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w_strobe_hi", 32'(STROBE), 32'(1'b1));
      chk("w_strobe_cs", 32'(sw_cs), 32'(2'b10));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk("w_hold_stb", 32'(STROBE), 32'(1'b0));
      chk("w_hold_cs", 32'(sw_cs), 32'(2'b10));
    end
    for (int i = 0; i < 9; i++) begin
      step();
      chk("w_gap_cs", 32'(sw_cs), 32'(2'b00));
      chk("w_gap_ax", 32'(AX), 32'(4'd6));
      chk("w_done", 32'(done), 32'(i == 8));
    end
    step();
    chk("w_idle_busy", 32'(busy), 32'(1'b0));

    // ---- 9 back-to-back writes ----
    pidx = 0; sidx = 0; rises = 0; last_rise = 0; cyc = 0; dones = 0;
    prev_stb = 1'b0;
    for (int c = 0; c < 220; c++) begin
      if (pidx < 9) begin
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = pidx[0];
        cmd_x = xs[pidx]; cmd_y = pidx[2:0]; cmd_data = pidx[0];
      end else begin
        cmd_valid = 1'b0;
      end
      rdy = cmd_ready;
      step();
      cyc++;
      if (cmd_valid && rdy) begin
        pidx++;
        if (pidx == 9) chk("full_ready_low", 32'(cmd_ready), 32'(1'b0));
      end
      if (STROBE && !prev_stb) begin
        rises++;
        if (sidx < 9) begin
          chk("burst_ax", 32'(AX), 32'(pxs[sidx]));
          chk("burst_ay", 32'(AY), 32'(sidx[2:0]));
          chk("burst_data", 32'(DATA), 32'(sidx[0]));
          chk("burst_cs", 32'(sw_cs), sidx[0] ? 32'(2'b10) : 32'(2'b01));
          if (sidx > 0) chk("burst_spacing", 32'(cyc - last_rise), 32'd17);
          last_rise = cyc;
          sidx++;
        end
      end
      prev_stb = STROBE;
      if (done) dones++;
      if (pidx == 9 && !busy) break;
    end
    cmd_valid = 1'b0;
    chk("burst_accepted", 32'(pidx), 32'd9);
    chk("burst_rises", 32'(rises), 32'd9);
    chk("burst_dones", 32'(dones), 32'd9);
    chk("burst_idle", 32'(busy), 32'(1'b0));

    // ---- reset chip 0 ----
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r0_rst", 32'(sw_rst), 32'(2'b01));
      chk("r0_cs", 32'(sw_cs), 32'(2'b00));
    end
    for (int i = 0; i < 9; i++) begin
      step();
      chk("r0_gap_rst", 32'(sw_rst), 32'(2'b00));
      chk("r0_done", 32'(done), 32'(i == 8));
    end
    step();
    chk("r0_idle", 32'(busy), 32'(1'b0));

    // ---- reset all chips ----
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_sel = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rall_rst", 32'(sw_rst), 32'(2'b11));
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      step();
    end
    chk("rall_idle", 32'(busy), 32'(1'b0));

    // ---- bad select on the three-chip instance ----
    v3 = 1'b1; op3 = 2'b00; sel3 = 2'd3; x3 = 4'd0; y3 = 3'd0; d3 = 1'b0;
    step();
    sel3 = 2'd2; x3 = 4'd13; y3 = 3'd1; d3 = 1'b1;
    chk("err_pulse", 32'(err3), 32'(1'b1));
    chk("err_no_cs", 32'(cs3), 32'(3'b000));
    step();
    v3 = 1'b0;
    chk("err_single", 32'(err3), 32'(1'b0));
    chk("err_no_stb", 32'(stb3), 32'(1'b0));
    step();
    chk("next_cs", 32'(cs3), 32'(3'b100));
    chk("next_ax", 32'(ax3), 32'(4'd7));
    chk("next_ay", 32'(ay3), 32'(3'd1));
    scnt = 0; dcnt = 0; ecnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy3) break;
      if (stb3) scnt++;
      if (done3) dcnt++;
      if (err3) ecnt++;
      step();
    end
    chk("next_strobes", 32'(scnt), 32'd3);
    chk("next_dones", 32'(dcnt), 32'd1);
    chk("next_errs", 32'(ecnt), 32'd0);
    chk("next_idle", 32'(busy3), 32'(1'b0));

    // ---- rst during STROBE ----
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 1'b0;
      cmd_x = 4'(i + 1); cmd_y = 3'd2; cmd_data = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (STROBE) begin
        found = 1;
        break;
      end
      step();
    end
    chk("abort_strobe_seen", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_strobe", 32'(STROBE), 32'(1'b0));
    chk("abort_cs", 32'(sw_cs), 32'(2'b00));
    chk("abort_ready", 32'(cmd_ready), 32'(1'b0));
    step();
    rst = 1'b0;
    check_init();
    chk("abort_no_strobe", 32'(STROBE), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
